instr_fetch: RTL and testbench

//   Instruction fetch stage for the MCU. Drives address and chip enable into

---
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding decode from a
// one-cycle-latency instruction RAM, with redirect, halt and hold buffer.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           decode cannot accept this cycle
//   branch_taken    redirect pulse, branch_target is the new address
//   halt_req        stop-fetch pulse (wins over branch_taken)
//   ram_dout        RAM data for the read issued last cycle
//   pc_final        RAM read address (combinational)
//   ce_ram          RAM read enable (combinational)
//   instr_out       instruction to decode (0 when not valid)
//   instr_pc        address of instr_out (0 when not valid)
//   instr_valid     instr_out/instr_pc valid
module instr_fetch #(
   parameter int ADDR_W     = 16,
   parameter int INSTR_W    = 20,
   parameter int IMEM_DEPTH = 256,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               halt_req,
   input  logic [INSTR_W-1:0] ram_dout,
   output logic [ADDR_W-1:0]  pc_final,
   output logic               ce_ram,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
);

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALTED
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 infl_q, infl_d;
   logic [ADDR_W-1:0]    infl_pc_q, infl_pc_d;
   logic                 hold_v_q, hold_v_d;
   logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0]    hold_pc_q, hold_pc_d;

   logic flush;
   logic xfer;
   logic fetch_ok;
   logic issue;

   // Redirect and halt both discard whatever decode would have seen.
   assign flush = branch_taken | halt_req;

   assign instr_valid = (hold_v_q | infl_q) & ~flush;
   assign xfer        = instr_valid & ~stall;

   // A branch revives a halted stage in the same cycle it arrives.
   assign fetch_ok = (state_q == S_RUN) |
                     ((state_q == S_HALTED) & branch_taken);

   // A pending word blocks a new read unless a redirect replaces it.
   assign issue = fetch_ok & ~halt_req &
                  (branch_taken | (~hold_v_q & ~(infl_q & stall)));

   assign pc_final = branch_taken ? branch_target : pc_q;
   assign ce_ram   = issue;

   // Hold entry is always the oldest word, so it has mux priority.
   always_comb begin
      instr_out = '0;
      instr_pc  = '0;
      if (instr_valid) begin
         if (hold_v_q) begin
            instr_out = hold_instr_q;
            instr_pc  = hold_pc_q;
         end else begin
            instr_out = ram_dout;
            instr_pc  = infl_pc_q;
         end
      end
   end

   // Fetch pointer and in-flight read tracking.
   always_comb begin
      pc_d      = pc_q;
      infl_d    = 1'b0;
      infl_pc_d = infl_pc_q;
      if (issue) begin
         infl_d    = 1'b1;
         infl_pc_d = pc_final;
         if (pc_final == LAST_PC) begin
            pc_d = '0;
         end else begin
            pc_d = pc_final + 1'b1;
         end
      end
   end

   // The RAM word is only present for one cycle, so a stalled
   // in-flight read must be parked in the hold entry.
   always_comb begin
      hold_v_d     = hold_v_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      if (flush) begin
         hold_v_d = 1'b0;
      end else if (hold_v_q) begin
         if (xfer) begin
            hold_v_d = 1'b0;
         end
      end else if (infl_q & stall) begin
         hold_v_d     = 1'b1;
         hold_instr_d = ram_dout;
         hold_pc_d    = infl_pc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (halt_req) begin
               state_d = S_HALTED;
            end
         end
         S_HALTED: begin
            if (branch_taken & ~halt_req) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         infl_q       <= 1'b0;
         infl_pc_q    <= '0;
         hold_v_q     <= 1'b0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         infl_q       <= infl_d;
         infl_pc_q    <= infl_pc_d;
         hold_v_q     <= hold_v_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: random and scripted stimulus for instr_fetch,
// compared each cycle against a queue-based fetch model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        halt_req;
   logic [19:0] ram_dout;
   logic [15:0] pc_final;
   logic        ce_ram;
   logic [19:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;

   logic [19:0] mem [256];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // model state: 0 idle, 1 run, 2 halted
   int m_mode;
   int m_pc;
   int qa[$];
   int qc[$];

   instr_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .ram_dout      (ram_dout),
      .pc_final      (pc_final),
      .ce_ram        (ce_ram),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid)
   );

   always #5 clk = ~clk;

   // RAM: one-cycle read; junk when not enabled
   always @(posedge clk) begin
      if (ce_ram) ram_dout <= mem[pc_final[7:0]];
      else        ram_dout <= 20'($urandom);
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                    tag, cyc, got, exp);
   endtask

   task automatic step(input bit s, input bit b, input int t,
                       input bit h, input bit r);
      bit ev, can, fresh, fetch;
      int ea, fa;
      logic [19:0] ei;
      @(negedge clk);
      stall         = s;
      branch_taken  = b;
      branch_target = 16'(t);
      halt_req      = h;
      rst           = r;
      #1;
      if (r) begin
         m_mode = 0;
         m_pc   = 0;
         qa.delete();
         qc.delete();
      end else begin
         ev    = qa.size() > 0 && !b && !h;
         ea    = ev ? qa[0] : 0;
         ei    = ev ? mem[ea[7:0]] : 20'h0;
         can   = m_mode == 1 || (m_mode == 2 && b);
         fresh = qa.size() > 0 && qc[0] == cyc - 1;
         fetch = can && !h && (b || qa.size() == 0 || (fresh && !s));
         fa    = b ? t : m_pc;
         chk("ce_ram",      32'(ce_ram),      32'(fetch));
         chk("pc_final",    32'(pc_final),    32'(fa));
         chk("instr_valid", 32'(instr_valid), 32'(ev));
         chk("instr_out",   32'(instr_out),   32'(ei));
         chk("instr_pc",    32'(instr_pc),    32'(ea));
         if (b || h) begin
            qa.delete();
            qc.delete();
         end else if (ev && !s) begin
            void'(qa.pop_front());
            void'(qc.pop_front());
         end
         if (fetch) begin
            qa.push_back(fa);
            qc.push_back(cyc);
            m_pc = (fa == 255) ? 0 : fa + 1;
         end
         case (m_mode)
            0: m_mode = 1;
            1: if (h) m_mode = 2;
            default: if (b && !h) m_mode = 1;
         endcase
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int t;
      for (int i = 0; i < 256; i++) mem[i] = 20'($urandom);
      rst = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      halt_req = 1'b0;
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      // start-up stream
      run(3);
      // stall while a word is valid
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      run(4);
      // redirect under stall
      step(1, 1, 16'h40, 0, 0);
      run(3);
      // sequential wrap 255 -> 0
      step(0, 1, 253, 0, 0);
      run(5);
      // halt, idle, then revive
      step(0, 0, 0, 1, 0);
      run(10);
      step(0, 1, 16'h10, 0, 0);
      run(3);
      // halt beats simultaneous branch
      step(0, 1, 5, 1, 0);
      run(2);
      step(0, 1, 8, 0, 0);
      run(2);
      // reset with hold entry full
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      run(4);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         t = ($urandom_range(0, 3) == 0) ? $urandom_range(250, 255)
                                         : $urandom_range(0, 255);
         step($urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 5, t,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 199) < 1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
